serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial unsigned subtractor computing `a - b` one bit per clock, LSB first, using a single borrow flip-flop. It is the inverse arithmetic counterpart of the combinational full adder. It is meant for the area-constrained neighbour-count and rule-evaluation paths, where a WIDTH-bit ripple subtractor per cell is too expensive. Operands enter and results leave through independent valid/ready handshakes.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range 2..32.

- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `start_valid`  in  1: operands `a`/`b` are valid.
- `start_ready`  out  1: block can accept operands.
- `a`  in  WIDTH: minuend, unsigned.
- `b`  in  WIDTH: subtrahend, unsigned.
- `result_valid`  out  1: `diff`/`borrow`/`zero` are valid.
- `result_ready`  in  1: consumer accepts the result.
- `diff`  out  WIDTH: `(a - b) mod 2^WIDTH`.
- `borrow`  out  1: final borrow; 1 iff `a < b` unsigned.
- `zero`  out  1: 1 iff `diff == 0`.

## Operation
- FSM states and transitions:
  - IDLE → BUSY on `start_valid && start_ready`.
  - BUSY → DONE after exactly WIDTH bit steps.
  - DONE → IDLE on `result_valid && result_ready`.
- Accept:
  - Latch `a` and `b` into internal shift registers.
  - Clear the borrow FF and the bit counter.
  - `a` and `b` are ignored at all other times.
- BUSY bit step i (0..WIDTH-1), with `ai`/`bi` the current LSBs of the shift registers:
  - `d = ai ^ bi ^ bin`
  - `bout = (~ai & bi) | (~(ai ^ bi) & bin)`
  - Shift `d` into the result register from the MSB side; after WIDTH steps, bit i sits at `diff[i]`.
  - Borrow FF takes `bout`.
- On entry to DONE:
  - `borrow` = borrow FF.
  - `zero` = NOR of the result register, registered.
- Outputs are held stable throughout DONE, regardless of `start_valid`.
- `start_ready` = 1 only in IDLE. No operand is accepted in BUSY or DONE.
- Bit counter width is `$clog2(WIDTH)+1`. It never wraps within one operation.
- Reset, from any state including mid-BUSY:
  - Next state is IDLE.
  - The partial result is discarded.
  - No `result_valid` pulse is issued for the aborted operation.
- Reset values: `start_ready`=1, `result_valid`=0, `diff`=0, `borrow`=0, `zero`=0; internal shift registers, borrow FF and counter = 0.
- Illegal/unused state encoding recovers to IDLE on the next edge.

## Timing
- Accept edge E0 → `result_valid` rises at edge E0+WIDTH, i.e. the latency is exactly WIDTH cycles.
- `start_ready` falls at E0 and stays low until the DONE → IDLE transition.
- Result handshake at edge Er:
  - `result_valid` falls at Er.
  - `start_ready` rises at Er.
  - The next accept can happen at Er+1.
- With `result_ready` held high, back-to-back throughput is one result per WIDTH+2 cycles.
- `result_valid` stays high indefinitely while `result_ready` = 0; there is no timeout.
- `reset` has priority over every handshake sampled on the same edge.
- `start_ready` and `result_valid` are decoded from registered state only; there is no combinational path from any input.

## Test plan
- WIDTH=8, a=10, b=3 → `result_valid` exactly 8 cycles after accept; `diff`=7, `borrow`=0, `zero`=0.
- a=3, b=10 → `diff`=0xF9, `borrow`=1, `zero`=0.
- a=0x55, b=0x55 → `diff`=0x00, `borrow`=0, `zero`=1.
- a=0x00, b=0x01 → `diff`=0xFF, `borrow`=1 (full borrow chain).
- a=0xFF, b=0x00 → `diff`=0xFF, `borrow`=0.
- Backpressure: hold `result_ready`=0 for 5 cycles after `result_valid` rises, pulsing `start_valid` with new operands → `diff`/`borrow`/`zero` unchanged, `start_ready`=0 throughout, new operands not captured. Raise `result_ready` → `start_ready`=1 on the next cycle.
- Reset asserted on the 4th BUSY cycle of a=200, b=100:
  - Next cycle: `start_ready`=1, `result_valid`=0, all outputs 0, and no result pulse ever follows.
  - A following op a=200, b=100 → `diff`=100, `borrow`=0.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// The master supplies operands and consumes results; the slave is the subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             result_valid;
  logic             result_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             zero;

  modport master (
    output start_valid,
    output a,
    output b,
    output result_ready,
    input  start_ready,
    input  result_valid,
    input  diff,
    input  borrow,
    input  zero
  );

  modport slave (
    input  start_valid,
    input  a,
    input  b,
    input  result_ready,
    output start_ready,
    output result_valid,
    output diff,
    output borrow,
    output zero
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b, one bit per clock, LSB first,
// with a single borrow flip-flop between bit steps.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for operands (start_ready = 1)
// BUSY  | one bit step per cycle, WIDTH steps in total
// DONE  | result held on diff/borrow/zero until result_ready
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  serial_subtractor_if.slave  bus
);

  localparam int             CW        = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state;
  state_t           state_nx;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_nx;
  logic             borrow_ff;
  logic             borrow_q;
  logic             zero_q;
  logic [CW-1:0]    cnt;

  logic             ai;
  logic             bi;
  logic             d;
  logic             bout;
  logic             last_step;
  logic             accept;
  logic             deliver;

  // One full-subtractor slice on the current LSBs plus handshake decodes.
  always_comb begin
    ai        = a_sh[0];
    bi        = b_sh[0];
    d         = ai ^ bi ^ borrow_ff;
    bout      = (~ai & bi) | (~(ai ^ bi) & borrow_ff);
    res_nx    = {d, res_sh[WIDTH-1:1]};
    last_step = (cnt == LAST_STEP);
    accept    = (state == IDLE) && bus.start_valid;
    deliver   = (state == DONE) && bus.result_ready;
  end

  // State register; reset wins over any handshake on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; the unused encoding falls back to IDLE.
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:    state_nx = accept    ? BUSY : IDLE;
      BUSY:    state_nx = last_step ? DONE : BUSY;
      DONE:    state_nx = deliver   ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, bit steps, and result registration on the final step.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh      <= '0;
      b_sh      <= '0;
      res_sh    <= '0;
      borrow_ff <= 1'b0;
      borrow_q  <= 1'b0;
      zero_q    <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_sh      <= bus.a;
            b_sh      <= bus.b;
            borrow_ff <= 1'b0;
            cnt       <= '0;
          end
        end
        BUSY: begin
          a_sh      <= a_sh >> 1;
          b_sh      <= b_sh >> 1;
          res_sh    <= res_nx;
          borrow_ff <= bout;
          // Counter stops at the last step so it can never wrap.
          if (!last_step) begin
            cnt <= cnt + CW'(1);
          end else begin
            borrow_q <= bout;
            zero_q   <= ~|res_nx;
          end
        end
        default: begin
          // DONE and the unused encoding hold every register.
        end
      endcase
    end
  end

  assign bus.start_ready  = (state == IDLE);
  assign bus.result_valid = (state == DONE);
  assign bus.diff         = res_sh;
  assign bus.borrow       = borrow_q;
  assign bus.zero         = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed cases with literal expectations plus
// a randomized run, all checked every cycle against a cycle-count model.
module tb_serial_subtractor;
  localparam int W = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) bus();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Model: an operation is accepted when idle, becomes visible W cycles
  // later, and retires on the first cycle result_ready is seen.
  bit           m_active = 1'b0;
  bit           m_clean  = 1'b1;
  int           m_age    = 0;
  logic [W-1:0] m_diff   = '0;
  logic         m_borrow = 1'b0;
  logic         m_zero   = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_active = 1'b0;
      m_clean  = 1'b1;
    end else if (!m_active) begin
      if (bus.start_valid) begin
        m_active = 1'b1;
        m_clean  = 1'b0;
        m_age    = 0;
        m_diff   = W'((int'(bus.a) - int'(bus.b)) & ((1 << W) - 1));
        m_borrow = (int'(bus.a) < int'(bus.b));
        m_zero   = (bus.a == bus.b);
      end
    end else if (m_age < W) begin
      m_age = m_age + 1;
    end else if (bus.result_ready) begin
      m_active = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  // Compare process: DUT outputs against the model on every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_start_ready", 32'(bus.start_ready), 32'(!m_active));
      check("m_result_valid", 32'(bus.result_valid), 32'(m_active && m_age == W));
      if (m_active && m_age == W) begin
        check("m_diff", 32'(bus.diff), 32'(m_diff));
        check("m_borrow", 32'(bus.borrow), 32'(m_borrow));
        check("m_zero", 32'(bus.zero), 32'(m_zero));
      end
      if (m_clean) begin
        check("m_clean_diff", 32'(bus.diff), 32'd0);
        check("m_clean_borrow", 32'(bus.borrow), 32'd0);
        check("m_clean_zero", 32'(bus.zero), 32'd0);
      end
    end
  end

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input logic [W-1:0] ed, input logic eb, input logic ez,
                       input int hold);
    int lat;
    @(negedge clk);
    bus.start_valid  = 1'b1;
    bus.a            = ta;
    bus.b            = tb_v;
    bus.result_ready = 1'b0;
    @(negedge clk);
    check("accept_ready_low", 32'(bus.start_ready), 32'd0);
    bus.start_valid = 1'b0;
    bus.a           = W'($urandom);
    bus.b           = W'($urandom);
    lat = 0;
    while (!bus.result_valid && lat < 4 * W) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'd8);
    check("lit_diff", 32'(bus.diff), 32'(ed));
    check("lit_borrow", 32'(bus.borrow), 32'(eb));
    check("lit_zero", 32'(bus.zero), 32'(ez));
    for (int i = 0; i < hold; i++) begin
      bus.start_valid = 1'b1;
      bus.a           = W'($urandom);
      bus.b           = W'($urandom);
      @(negedge clk);
      check("bp_start_ready", 32'(bus.start_ready), 32'd0);
      check("bp_valid", 32'(bus.result_valid), 32'd1);
      check("bp_diff", 32'(bus.diff), 32'(ed));
      check("bp_borrow", 32'(bus.borrow), 32'(eb));
      check("bp_zero", 32'(bus.zero), 32'(ez));
    end
    bus.start_valid  = 1'b0;
    bus.result_ready = 1'b1;
    @(negedge clk);
    bus.result_ready = 1'b0;
    check("ready_after_handshake", 32'(bus.start_ready), 32'd1);
    check("valid_after_handshake", 32'(bus.result_valid), 32'd0);
  endtask

  initial begin
    bus.start_valid  = 1'b0;
    bus.a            = '0;
    bus.b            = '0;
    bus.result_ready = 1'b0;
    reset            = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_start_ready", 32'(bus.start_ready), 32'd1);
    check("rst_result_valid", 32'(bus.result_valid), 32'd0);
    check("rst_diff", 32'(bus.diff), 32'd0);
    reset = 1'b0;

    do_op(8'd10, 8'd3, 8'd7, 1'b0, 1'b0, 0);
    do_op(8'd3, 8'd10, 8'hF9, 1'b1, 1'b0, 0);
    do_op(8'h55, 8'h55, 8'h00, 1'b0, 1'b1, 0);
    do_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 0);
    do_op(8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0, 0);
    do_op(8'd10, 8'd3, 8'd7, 1'b0, 1'b0, 5);

    // Abort an operation with reset on its 4th BUSY cycle.
    @(negedge clk);
    bus.start_valid = 1'b1;
    bus.a           = 8'd200;
    bus.b           = 8'd100;
    @(negedge clk);
    bus.start_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_start_ready", 32'(bus.start_ready), 32'd1);
    check("abort_valid", 32'(bus.result_valid), 32'd0);
    check("abort_diff", 32'(bus.diff), 32'd0);
    check("abort_borrow", 32'(bus.borrow), 32'd0);
    check("abort_zero", 32'(bus.zero), 32'd0);
    for (int i = 0; i < 3 * W; i++) begin
      @(negedge clk);
      check("abort_no_pulse", 32'(bus.result_valid), 32'd0);
    end
    do_op(8'd200, 8'd100, 8'd100, 1'b0, 1'b0, 0);

    // Randomized traffic with random backpressure and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bus.start_valid  = $urandom_range(0, 1) == 1;
      bus.a            = ($urandom_range(0, 7) == 0) ? bus.b : W'($urandom);
      bus.b            = W'($urandom);
      bus.result_ready = $urandom_range(0, 3) != 0;
      reset            = $urandom_range(0, 199) == 0;
    end
    @(negedge clk);
    bus.start_valid  = 1'b0;
    bus.result_ready = 1'b0;
    reset            = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
